counter_cmd_sched: RTL
======================

# counter_cmd_sched

Command scheduler that shares one external up/down counter datapath between two requesters. Each requester issues a command: count up N steps, count down N steps, load a value, or clear. The block arbitrates round-robin and sequences the counter's hold/up_down/load controls cycle by cycle. When a command finishes, it reports the counter value and the served requester. It sits between the requester logic and the counter core, and owns every counter control input.

## Interface
Parameters:
- WIDTH, 32, counter/data width
- STEPW, 8, step-count width (max 2^STEPW-1 steps per command)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- req0_valid  in  1  requester 0 command valid
- req0_op  in  2  00=UP, 01=DOWN, 10=LOAD, 11=CLEAR
- req0_steps  in  STEPW  step count for UP/DOWN; ignored otherwise
- req0_data  in  WIDTH  load value for LOAD; ignored otherwise
- req0_ready  out  1  requester 0 command accepted this cycle
- req1_valid, req1_op, req1_steps, req1_data, req1_ready  same for requester 1
- cnt_value  in  WIDTH  current counter value from datapath
- cnt_hold  out  1  1 = counter holds
- cnt_up_down  out  1  1 = increment, 0 = decrement
- cnt_load  out  1  1 = counter loads cnt_load_val this cycle
- cnt_load_val  out  WIDTH  load value
- busy  out  1  command in progress (state != IDLE)
- done  out  1  one-cycle completion pulse
- done_id  out  1  requester served by the completed command
- result  out  WIDTH  cnt_value captured at completion; held until next completion

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Grant is computed combinationally from the valid inputs.
  - With a single valid, that requester wins.
  - With both valid, the winner is the requester not served last. The last-served pointer resets to 1, so req0 wins the first tie.
  - reqX_ready = (state==IDLE) && grantX && !rst. At most one ready is high.
  - Acceptance means valid && ready. On acceptance the block latches op, steps, data and id, updates the last-served pointer, and goes to RUN.
  - UP/DOWN with steps==0 goes straight to DONE.
- RUN, UP/DOWN:
  - cnt_hold=0 and cnt_up_down=(op==UP) every RUN cycle.
  - The remaining count decrements each cycle. Exactly `steps` RUN cycles occur; the block moves to DONE after the cycle where remaining==1.
- RUN, LOAD: exactly one RUN cycle with cnt_load=1, cnt_load_val=latched data, cnt_hold=1. Then DONE.
- RUN, CLEAR: same as LOAD with cnt_load_val=0.
- DONE: one cycle.
  - cnt_hold=1, cnt_load=0.
  - At the end of the cycle: result<=cnt_value, done_id<=latched id, done<=1, state->IDLE.
- done is registered. It is high for exactly the one cycle after DONE and 0 otherwise.
- Outside RUN: cnt_hold=1, cnt_load=0.
- cnt_up_down holds its last driven value outside UP/DOWN RUN cycles.
- Counter wrap-around is the datapath's behaviour. The scheduler issues steps blindly and does not saturate.
- Commands are never cancelled. A valid that is held while the other requester is being served waits in IDLE arbitration.
- Reset, asserted at any time including mid-RUN, takes effect immediately:
  - state=IDLE, cnt_hold=1, cnt_load=0, cnt_load_val=0, cnt_up_down=1
  - busy=0, done=0, done_id=0, result=0, last-served=1
  - both readys 0 while rst is high
- The partially executed command is lost. Steps already taken are not undone.

## Timing
- Acceptance at edge k (IDLE, valid&&ready).
- UP/DOWN with steps=N≥1:
  - RUN cycles k+1..k+N.
  - DONE cycle k+N+1.
  - done high in cycle k+N+2.
  - result then equals start value ±N (mod 2^WIDTH).
- UP/DOWN with steps=0: DONE in cycle k+1, done in k+2, result = unchanged value.
- LOAD/CLEAR: RUN cycle k+1, DONE k+2, done k+3.
- Back-to-back: the cycle in which done is high is IDLE, so ready may assert in that same cycle. Maximum throughput is one command per steps+2 cycles (LOAD/CLEAR: 3).
- busy is high from cycle k+1 through the DONE cycle inclusive.

## Test plan
- Reset, then req0 UP steps=5 from counter 0: ready high the same cycle; exactly 5 cycles with cnt_hold=0, cnt_up_down=1; done 7 cycles after acceptance; result=5, done_id=0.
- req0 LOAD 0x10, then req0 DOWN steps=3: cnt_load pulses once with cnt_load_val=0x10; result after the second command = 0xD.
- Both valid continuously with UP steps=1 each: grant order req0, req1, req0, req1; never two readys in one cycle; each done_id alternates.
- Counter at 0, DOWN steps=1: result=0xFFFFFFFF. Then CLEAR: result=0.
- UP steps=0: no cnt_hold=0 cycle; done 2 cycles after acceptance; result unchanged.
- Assert rst during RUN of UP steps=200: next sample shows cnt_hold=1, busy=0, done=0, result=0, readys=0; after release, req1-only valid is accepted first cycle, then both-valid tie goes to req0.

Source files
------------

// File: rtl/counter_cmd_sched.sv
// counter_cmd_sched: shares one external up/down counter between two requesters.
// Each requester issues UP/DOWN N steps, LOAD value or CLEAR. Ties are arbitrated
// round-robin. The block sequences the counter's hold/up_down/load controls and
// reports the counter value and the served requester when a command completes.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   reqX_valid/op/steps/data  command from requester X (op: 00 UP, 01 DOWN, 10 LOAD, 11 CLEAR)
//   reqX_ready                command from requester X accepted this cycle
//   cnt_value                 current counter value from the datapath
//   cnt_hold/up_down/load     counter controls, cnt_load_val is the load value
//   busy                      a command is in progress
//   done, done_id, result     completion pulse, served requester, captured counter value
module counter_cmd_sched #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEPW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [STEPW-1:0] req0_steps,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [STEPW-1:0] req1_steps,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_hold,
    output logic             cnt_up_down,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_val,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] result
);

    localparam logic [1:0] OpUp   = 2'b00;
    localparam logic [1:0] OpLoad = 2'b10;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [STEPW-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               id_q, id_d;
    logic               last_q, last_d;
    logic               up_down_q, up_down_d;
    logic               done_q, done_d;
    logic               done_id_q, done_id_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               grant0, grant1;
    logic [1:0]         sel_op;
    logic [STEPW-1:0]   sel_steps;

    always_comb begin
        // A lone valid wins; on a tie the requester not served last wins.
        grant0 = req0_valid && (!req1_valid || last_q);
        grant1 = req1_valid && (!req0_valid || !last_q);
        req0_ready = (state_q == StIdle) && grant0 && !rst;
        req1_ready = (state_q == StIdle) && grant1 && !rst;

        sel_op    = req1_ready ? req1_op : req0_op;
        sel_steps = req1_ready ? req1_steps : req0_steps;

        state_d      = state_q;
        op_d         = op_q;
        rem_d        = rem_q;
        data_d       = data_q;
        id_d         = id_q;
        last_d       = last_q;
        up_down_d    = up_down_q;
        done_d       = 1'b0;
        done_id_d    = done_id_q;
        result_d     = result_q;
        cnt_hold     = 1'b1;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_up_down  = up_down_q;

        case (state_q)
            StIdle: begin
                if (req0_ready || req1_ready) begin
                    id_d   = req1_ready;
                    last_d = req1_ready;
                    op_d   = sel_op;
                    rem_d  = sel_steps;
                    data_d = req1_ready ? req1_data : req0_data;
                    // A zero-step count has nothing to run.
                    if (!sel_op[1] && (sel_steps == '0)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (!op_q[1]) begin
                    cnt_hold    = 1'b0;
                    cnt_up_down = (op_q == OpUp);
                    up_down_d   = (op_q == OpUp);
                    rem_d       = rem_q - STEPW'(1);
                    if (rem_q == STEPW'(1)) begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_load     = 1'b1;
                    cnt_load_val = (op_q == OpLoad) ? data_q : '0;
                    state_d      = StDone;
                end
            end
            StDone: begin
                result_d  = cnt_value;
                done_id_d = id_q;
                done_d    = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= 2'b00;
            rem_q     <= '0;
            data_q    <= '0;
            id_q      <= 1'b0;
            last_q    <= 1'b1;
            up_down_q <= 1'b1;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rem_q     <= rem_d;
            data_q    <= data_d;
            id_q      <= id_d;
            last_q    <= last_d;
            up_down_q <= up_down_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            result_q  <= result_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign done_id = done_id_q;
    assign result  = result_q;

endmodule
